pending_encoder: RTL

PENDING_ENCODER -- requirements
Module: pending_encoder

---
 rtl/pending_encoder_if.sv | 31 +++
 rtl/pending_encoder.sv | 111 +++++++++++
 2 files changed

// File: rtl/pending_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : pending_encoder_if
// Brief    : Capture/handshake bundle for pending_encoder (requests, grant
//            slot, pending count).
// Revision : 1.0
// ============================================================================
interface pending_encoder_if #(
    parameter int N = 8
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    logic              en;
    logic [N-1:0]      req;
    logic              out_ready;
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic [CNT_W-1:0]  pend_cnt;

    modport master (
        output en, req, out_ready,
        input  out_valid, out_idx, pend_cnt
    );

    modport slave (
        input  en, req, out_ready,
        output out_valid, out_idx, pend_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pending_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pending_encoder
// Brief    : Sticky request register drained one index per grant through a
//            valid/ready slot. Define ROUND_ROBIN_EN for rotating priority,
//            otherwise the highest pending index wins.
// Revision : 1.0
// ============================================================================
module pending_encoder #(
    parameter int N = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pending_encoder_if.slave  bus
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    logic [N-1:0]     r_pend;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;

    logic [N-1:0]     w_set;
    logic [N-1:0]     w_clear;
    logic [N-1:0]     w_pend_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [IDX_W-1:0] w_sel;
    logic             w_free;
    logic             w_load;

    assign w_free = !r_valid || bus.out_ready;
    assign w_load = w_free && (r_pend != '0);
    assign w_set  = bus.en ? bus.req : '0;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_pos;
    logic             w_found;

    // Scan ptr, ptr-1, ..., wrapping modulo N; first pending bit wins.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, r_ptr} + (IDX_W+1)'(N - k);
            if (w_pos >= (IDX_W+1)'(N)) begin
                w_pos = w_pos - (IDX_W+1)'(N);
            end
            if (!w_found && r_pend[w_pos[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_pos[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDX_W'(N - 1);
        end else if (w_load) begin
            r_ptr <= (w_sel == '0) ? IDX_W'(N - 1) : (w_sel - 1'b1);
        end
    end
`else
    // Ascending scan: the last (highest) pending index overwrites earlier ones.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (r_pend[i]) begin
                w_sel = IDX_W'(i);
            end
        end
    end
`endif

    // A fresh request on a bit being granted re-arms it: set wins over clear.
    assign w_clear     = w_load ? ({{(N-1){1'b0}}, 1'b1} << w_sel) : '0;
    assign w_pend_next = (r_pend & ~w_clear) | w_set;

    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt_next = w_cnt_next + CNT_W'(w_pend_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_pend <= w_pend_next;
            r_cnt  <= w_cnt_next;
            if (w_load) begin
                r_valid <= 1'b1;
                r_idx   <= w_sel;
            end else if (w_free) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_idx   = r_idx;
    assign bus.pend_cnt  = r_cnt;

endmodule
`default_nettype wire
